// File: rtl/mc_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle MIPS controller: opcodes, functs,
// ALU/operand-select encodings, FSM states and decoded instruction classes.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_RT      = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_WB_R,
        S_EXEC_I,
        S_WB_I,
        S_MEM_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_SW,
        CLS_BNE
    } instr_cls_e;

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Controller <-> datapath/memory bundle: IR fields and flags in, control strobes out.
interface mc_ctrl_fsm_if;

    logic [5:0] op_code;
    logic [5:0] op_funct;
    logic       alu_zero;
    logic       mem_ack;

    logic       mem_req;
    logic       mem_we;
    logic       i_or_d;
    logic       ir_write;
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       instr_done;
    logic       illegal;
    logic       bus_err;

    modport master (
        input  op_code, op_funct, alu_zero, mem_ack,
        output mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal, bus_err
    );

    modport slave (
        output op_code, op_funct, alu_zero, mem_ack,
        input  mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
               reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op,
               instr_done, illegal, bus_err
    );

endinterface

// File: rtl/mc_ctrl_fsm_decode.sv
// Combinational instruction decode: opcode/funct -> instruction class, ALU
// operation for the execute step, and an unsupported-instruction flag.
module cu_instr_decode
    import mips_pkg::*;
(
    input  logic [5:0]  i_op_code,
    input  logic [5:0]  i_op_funct,
    output instr_cls_e  o_cls,
    output logic [2:0]  o_alu_op,
    output logic        o_illegal
);

    always_comb begin
        o_cls     = CLS_R;
        o_alu_op  = ALU_ADD;
        o_illegal = 1'b0;
        case (i_op_code)
            OP_RTYPE: begin
                case (i_op_funct)
                    FN_ADD:  o_alu_op = ALU_ADD;
                    FN_SUB:  o_alu_op = ALU_SUB;
                    FN_AND:  o_alu_op = ALU_AND;
                    FN_OR:   o_alu_op = ALU_OR;
                    FN_SLT:  o_alu_op = ALU_SLT;
                    default: o_illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin o_cls = CLS_I; o_alu_op = ALU_ADD; end
            OP_SLTI: begin o_cls = CLS_I; o_alu_op = ALU_SLT; end
            OP_ANDI: begin o_cls = CLS_I; o_alu_op = ALU_AND; end
            OP_ORI:  begin o_cls = CLS_I; o_alu_op = ALU_OR;  end
            OP_LW:   o_cls = CLS_LW;
            OP_SW:   o_cls = CLS_SW;
            OP_BNE:  begin o_cls = CLS_BNE; o_alu_op = ALU_SUB; end
            default: o_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS controller: sequences the shared ALU, memory port and
// register file, with a memory-ack timeout and sticky illegal/bus-error flags.
//
// state      | meaning
// S_FETCH    | read instruction at PC, PC <= PC+4 on ack
// S_DECODE   | branch target into ALUOut, dispatch on opcode
// S_EXEC_R   | rs op rt
// S_WB_R     | write ALUOut to rd
// S_EXEC_I   | rs op sign-ext imm
// S_WB_I     | write ALUOut to rt
// S_MEM_ADDR | rs + sign-ext imm (load/store address)
// S_MEM_RD   | data read at ALUOut, wait for ack
// S_MEM_WB   | write memory data to rt
// S_MEM_WR   | data write at ALUOut, wait for ack
// S_BRANCH   | compare rs/rt, load PC from ALUOut if not equal
// S_TRAP     | halted until reset
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 15
)
(
    input  logic          clk,
    input  logic          rst_n,
    mc_ctrl_fsm_if.master bus
);

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_e     r_state;
    state_e     w_state_next;
    logic [7:0] r_tmo_cnt;
    logic       r_illegal;
    logic       r_bus_err;

    instr_cls_e w_cls;
    logic [2:0] w_dec_alu_op;
    logic       w_dec_illegal;

    logic       w_set_illegal;
    logic       w_set_bus_err;
    logic       w_tmo_expire;

    logic       w_mem_req;
    logic       w_mem_we;
    logic       w_i_or_d;
    logic       w_ir_write;
    logic       w_pc_write;
    logic       w_pc_src;
    logic       w_reg_write;
    logic       w_reg_dst;
    logic       w_mem_to_reg;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic [2:0] w_alu_op;
    logic       w_instr_done;

    cu_instr_decode u_decode (
        .i_op_code  (bus.op_code),
        .i_op_funct (bus.op_funct),
        .o_cls      (w_cls),
        .o_alu_op   (w_dec_alu_op),
        .o_illegal  (w_dec_illegal)
    );

    // One more missing ack would bring the wait to TIMEOUT_CYCLES; an ack this cycle still wins.
    assign w_tmo_expire = ~bus.mem_ack && (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_state_next  = r_state;
        w_set_illegal = 1'b0;
        w_set_bus_err = 1'b0;
        w_mem_req     = 1'b0;
        w_mem_we      = 1'b0;
        w_i_or_d      = 1'b0;
        w_ir_write    = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 1'b0;
        w_reg_write   = 1'b0;
        w_reg_dst     = 1'b0;
        w_mem_to_reg  = 1'b0;
        w_alu_src_a   = 1'b0;
        w_alu_src_b   = SRCB_RT;
        w_alu_op      = ALU_AND;
        w_instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req   = 1'b1;
                w_alu_src_b = SRCB_FOUR;
                w_alu_op    = ALU_ADD;
                if (bus.mem_ack) begin
                    w_ir_write   = 1'b1;
                    w_pc_write   = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_tmo_expire) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = S_TRAP;
                end
            end
            S_DECODE: begin
                w_alu_src_b = SRCB_IMM_SH2;
                w_alu_op    = ALU_ADD;
                if (w_dec_illegal) begin
                    w_set_illegal = 1'b1;
                    w_state_next  = S_TRAP;
                end else begin
                    case (w_cls)
                        CLS_R:   w_state_next = S_EXEC_R;
                        CLS_I:   w_state_next = S_EXEC_I;
                        CLS_BNE: w_state_next = S_BRANCH;
                        default: w_state_next = S_MEM_ADDR;
                    endcase
                end
            end
            S_EXEC_R: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_RT;
                w_alu_op     = w_dec_alu_op;
                w_state_next = S_WB_R;
            end
            S_WB_R: begin
                w_reg_write  = 1'b1;
                w_reg_dst    = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_EXEC_I: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = w_dec_alu_op;
                w_state_next = S_WB_I;
            end
            S_WB_I: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_ADDR: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_IMM;
                w_alu_op     = ALU_ADD;
                w_state_next = (w_cls == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                w_i_or_d  = 1'b1;
                if (bus.mem_ack) begin
                    w_state_next = S_MEM_WB;
                end else if (w_tmo_expire) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = S_TRAP;
                end
            end
            S_MEM_WB: begin
                w_reg_write  = 1'b1;
                w_mem_to_reg = 1'b1;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                w_i_or_d  = 1'b1;
                if (bus.mem_ack) begin
                    w_instr_done = 1'b1;
                    w_state_next = S_FETCH;
                end else if (w_tmo_expire) begin
                    w_set_bus_err = 1'b1;
                    w_state_next  = S_TRAP;
                end
            end
            S_BRANCH: begin
                w_alu_src_a  = 1'b1;
                w_alu_src_b  = SRCB_RT;
                w_alu_op     = ALU_SUB;
                w_pc_src     = 1'b1;
                w_pc_write   = ~bus.alu_zero;
                w_instr_done = 1'b1;
                w_state_next = S_FETCH;
            end
            default: w_state_next = S_TRAP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_FETCH;
            r_tmo_cnt <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_state_next != r_state) begin
                r_tmo_cnt <= '0;
            end else if (w_mem_req && !bus.mem_ack) begin
                r_tmo_cnt <= r_tmo_cnt + 8'd1;
            end
            if (w_set_illegal) begin
                r_illegal <= 1'b1;
            end
            if (w_set_bus_err) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // The state register resets to FETCH, whose mem_req is 1, so every output is gated by rst_n.
    assign bus.mem_req    = rst_n & w_mem_req;
    assign bus.mem_we     = rst_n & w_mem_we;
    assign bus.i_or_d     = rst_n & w_i_or_d;
    assign bus.ir_write   = rst_n & w_ir_write;
    assign bus.pc_write   = rst_n & w_pc_write;
    assign bus.pc_src     = rst_n & w_pc_src;
    assign bus.reg_write  = rst_n & w_reg_write;
    assign bus.reg_dst    = rst_n & w_reg_dst;
    assign bus.mem_to_reg = rst_n & w_mem_to_reg;
    assign bus.alu_src_a  = rst_n & w_alu_src_a;
    assign bus.alu_src_b  = {2{rst_n}} & w_alu_src_b;
    assign bus.alu_op     = {3{rst_n}} & w_alu_op;
    assign bus.instr_done = rst_n & w_instr_done;
    assign bus.illegal    = rst_n & r_illegal;
    assign bus.bus_err    = rst_n & r_bus_err;

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: a per-cycle vector table plus hand-written
// sequences for delayed acks, timeouts, illegal opcodes and mid-access reset.
module tb_mc_ctrl_fsm;

    logic clk;
    logic rst_n;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(.TIMEOUT_CYCLES(15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output word: {mem_req, mem_we, i_or_d, ir_write, pc_write, pc_src,
    // reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b[1:0], alu_op[2:0],
    // instr_done, illegal, bus_err}
    localparam logic [17:0] E_ZERO = 18'h00000;
    localparam logic [17:0] E_F    = 18'h20050;
    localparam logic [17:0] E_FA   = 18'h26050;
    localparam logic [17:0] E_D    = 18'h000D0;
    localparam logic [17:0] E_WBR  = 18'h00C04;
    localparam logic [17:0] E_WBI  = 18'h00804;
    localparam logic [17:0] E_MA   = 18'h00190;
    localparam logic [17:0] E_RD   = 18'h28000;
    localparam logic [17:0] E_MWB  = 18'h00A04;
    localparam logic [17:0] E_WR   = 18'h38000;
    localparam logic [17:0] E_WRA  = 18'h38004;
    localparam logic [17:0] E_BR   = 18'h01134;
    localparam logic [17:0] E_BRT  = 18'h03134;
    localparam logic [17:0] E_ILL  = 18'h00002;
    localparam logic [17:0] E_BERR = 18'h00001;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        zero;
        logic        ack;
        logic [17:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [17:0] observed();
        return {bus.mem_req, bus.mem_we, bus.i_or_d, bus.ir_write, bus.pc_write,
                bus.pc_src, bus.reg_write, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal, bus.bus_err};
    endfunction

    task automatic check(input string nm, input logic [17:0] exp);
        logic [17:0] got;
        got = observed();
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: outputs got %05h expected %05h", nm, got, exp);
        end
    endtask

    task automatic add_vec(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input logic ack, input logic [17:0] exp,
                           input string nm);
        vec_t v;
        v.rst = rst; v.op = op; v.fn = fn; v.zero = zero; v.ack = ack; v.exp = exp; v.nm = nm;
        vecs.push_back(v);
    endtask

    // Called at a falling edge; drives, checks, and returns at the next falling edge.
    task automatic apply(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                         input logic zero, input logic ack, input logic [17:0] exp,
                         input string nm);
        rst_n        = rst;
        bus.op_code  = op;
        bus.op_funct = fn;
        bus.alu_zero = zero;
        bus.mem_ack  = ack;
        #1;
        check(nm, exp);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        bus.mem_ack = 1'b0;
        #1;
        check("reset_zero", E_ZERO);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_rtype(input logic [5:0] fn, input logic [17:0] e_exec, input string nm);
        add_vec(1, 6'b000000, fn, 0, 1, E_FA,   {nm, "_fetch"});
        add_vec(1, 6'b000000, fn, 0, 0, E_D,    {nm, "_decode"});
        add_vec(1, 6'b000000, fn, 0, 0, e_exec, {nm, "_exec"});
        add_vec(1, 6'b000000, fn, 0, 0, E_WBR,  {nm, "_wb"});
    endtask

    task automatic add_itype(input logic [5:0] op, input logic [17:0] e_exec, input string nm);
        add_vec(1, op, 6'h00, 0, 1, E_FA,   {nm, "_fetch"});
        add_vec(1, op, 6'h00, 0, 0, E_D,    {nm, "_decode"});
        add_vec(1, op, 6'h00, 0, 0, e_exec, {nm, "_exec"});
        add_vec(1, op, 6'h00, 0, 0, E_WBI,  {nm, "_wb"});
    endtask

    initial begin
        rst_n        = 1'b0;
        bus.op_code  = '0;
        bus.op_funct = '0;
        bus.alu_zero = 1'b0;
        bus.mem_ack  = 1'b0;

        add_vec(0, 6'h00, 6'h00, 0, 0, E_ZERO, "reset_idle");
        add_vec(0, 6'h00, 6'h00, 0, 1, E_ZERO, "reset_ack");
        add_rtype(6'b100000, 18'h00110, "add");
        add_rtype(6'b100010, 18'h00130, "sub");
        add_rtype(6'b100100, 18'h00100, "and");
        add_rtype(6'b100101, 18'h00108, "or");
        add_rtype(6'b101010, 18'h00138, "slt");
        add_itype(6'b001000, 18'h00190, "addi");
        add_itype(6'b001010, 18'h001B8, "slti");
        add_itype(6'b001100, 18'h00180, "andi");
        add_itype(6'b001101, 18'h00188, "ori");
        add_vec(1, 6'b100011, 6'h00, 0, 1, E_FA,  "lw_fetch");
        add_vec(1, 6'b100011, 6'h00, 0, 0, E_D,   "lw_decode");
        add_vec(1, 6'b100011, 6'h00, 0, 0, E_MA,  "lw_addr");
        add_vec(1, 6'b100011, 6'h00, 0, 1, E_RD,  "lw_rd");
        add_vec(1, 6'b100011, 6'h00, 0, 0, E_MWB, "lw_wb");
        add_vec(1, 6'b101011, 6'h00, 0, 1, E_FA,  "sw_fetch");
        add_vec(1, 6'b101011, 6'h00, 0, 0, E_D,   "sw_decode");
        add_vec(1, 6'b101011, 6'h00, 0, 0, E_MA,  "sw_addr");
        add_vec(1, 6'b101011, 6'h00, 0, 1, E_WRA, "sw_wr_ack");
        add_vec(1, 6'b000101, 6'h00, 0, 1, E_FA,  "bne_t_fetch");
        add_vec(1, 6'b000101, 6'h00, 0, 1, E_D,   "bne_t_decode_stray_ack");
        add_vec(1, 6'b000101, 6'h00, 0, 1, E_BRT, "bne_taken");
        add_vec(1, 6'b000101, 6'h00, 1, 0, E_F,   "bne_nt_fetch_wait");
        add_vec(1, 6'b000101, 6'h00, 1, 1, E_FA,  "bne_nt_fetch");
        add_vec(1, 6'b000101, 6'h00, 1, 0, E_D,   "bne_nt_decode");
        add_vec(1, 6'b000101, 6'h00, 1, 0, E_BR,  "bne_not_taken");
        add_vec(1, 6'b000000, 6'b000000, 0, 1, E_FA,  "badfn_fetch");
        add_vec(1, 6'b000000, 6'b000000, 0, 0, E_D,   "badfn_decode");
        add_vec(1, 6'b000000, 6'b000000, 0, 0, E_ILL, "badfn_trap");
        add_vec(1, 6'b000000, 6'b000000, 0, 1, E_ILL, "badfn_trap_ack");
        add_vec(0, 6'b000000, 6'b000000, 0, 0, E_ZERO, "badfn_reset");
        add_vec(1, 6'b000000, 6'b000000, 0, 0, E_F,    "badfn_refetch");

        @(negedge clk);
        foreach (vecs[i]) begin
            apply(vecs[i].rst, vecs[i].op, vecs[i].fn, vecs[i].zero, vecs[i].ack,
                  vecs[i].exp, vecs[i].nm);
        end

        // lw with ack arriving on the 4th MEM_RD cycle
        do_reset();
        apply(1, 6'b100011, 6'h00, 0, 1, E_FA, "lwd_fetch");
        apply(1, 6'b100011, 6'h00, 0, 0, E_D,  "lwd_decode");
        apply(1, 6'b100011, 6'h00, 0, 0, E_MA, "lwd_addr");
        for (int k = 0; k < 3; k++) apply(1, 6'b100011, 6'h00, 0, 0, E_RD, "lwd_rd_wait");
        apply(1, 6'b100011, 6'h00, 0, 1, E_RD,  "lwd_rd_ack");
        apply(1, 6'b100011, 6'h00, 0, 0, E_MWB, "lwd_wb");
        apply(1, 6'b100011, 6'h00, 0, 0, E_F,   "lwd_next_fetch");

        // unknown opcode traps with no further memory requests
        do_reset();
        apply(1, 6'b111111, 6'h00, 0, 1, E_FA, "ill_fetch");
        apply(1, 6'b111111, 6'h00, 0, 0, E_D,  "ill_decode");
        for (int k = 0; k < 4; k++) apply(1, 6'b111111, 6'h00, 0, k[0], E_ILL, "ill_trap_hold");
        do_reset();
        apply(1, 6'b000000, 6'b100000, 0, 0, E_F, "ill_cleared_fetch");

        // fetch timeout: 15 cycles without ack
        do_reset();
        for (int k = 0; k < 15; k++) apply(1, 6'h00, 6'b100000, 0, 0, E_F, "tmo_fetch_wait");
        apply(1, 6'h00, 6'b100000, 0, 0, E_BERR, "tmo_trap");
        apply(1, 6'h00, 6'b100000, 0, 1, E_BERR, "tmo_trap_ack");

        // ack on the 15th cycle beats the timeout
        do_reset();
        for (int k = 0; k < 14; k++) apply(1, 6'h00, 6'b100000, 0, 0, E_F, "tmo_edge_wait");
        apply(1, 6'h00, 6'b100000, 0, 1, E_FA,    "tmo_edge_ack");
        apply(1, 6'h00, 6'b100000, 0, 0, E_D,     "tmo_edge_decode");
        apply(1, 6'h00, 6'b100000, 0, 0, 18'h110, "tmo_edge_exec");
        apply(1, 6'h00, 6'b100000, 0, 0, E_WBR,   "tmo_edge_wb");

        // asynchronous reset in the middle of a store
        do_reset();
        apply(1, 6'b101011, 6'h00, 0, 1, E_FA, "rsw_fetch");
        apply(1, 6'b101011, 6'h00, 0, 0, E_D,  "rsw_decode");
        apply(1, 6'b101011, 6'h00, 0, 0, E_MA, "rsw_addr");
        apply(1, 6'b101011, 6'h00, 0, 0, E_WR, "rsw_wr_wait");
        #3;
        rst_n = 1'b0;
        #1;
        check("rsw_async_reset", E_ZERO);
        @(negedge clk);
        apply(1, 6'b101011, 6'h00, 0, 0, E_F, "rsw_refetch");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
